// File: rtl/exc_flush_ctrl.sv
//------------------------------------------------------------------------------
// exc_flush_ctrl
//
// Exception / ERTN sequencer that sits between the WB stage and the CSR file.
// It picks the highest-priority cause from the WB instruction's exception flags
// and the pending interrupt, then drives the CSR commit strobes. It also runs
// the flush handshake that redirects fetch to EENTRY (exception) or ERA (ERTN).
//
// Optional feature macro: CSR_EXC_INT_EN
//   defined   : interrupts (CRMD.IE & ESTAT.IS & ECFG.LIE) are taken, ecode 0x0
//   undefined : interrupts are never taken; the interrupt CSR inputs are unused
//
// Parameters
//   DRAIN_CYCLES  cycles WB stays blocked after fetch accepts the redirect (1..15)
//   CNT_W         width of the saturating exception counter
//
// Ports
//   clk, resetn      clock, synchronous active-low reset
//   wb_valid         WB holds a valid instruction
//   wb_pc            PC of the WB instruction
//   wb_vaddr         faulting address (ADEF: pc, ALE: data address)
//   wb_exc           {ale,brk,sys,ine,adef} flags of the WB instruction
//   wb_ertn          WB instruction is ERTN
//   csr_crmd_ie      CRMD.IE
//   csr_estat_is     ESTAT.IS[12:0]
//   csr_ecfg_lie     ECFG.LIE[12:0]
//   csr_eentry       EENTRY value (exception redirect target)
//   csr_era          ERA value (ERTN redirect target)
//   fe_ready         fetch accepts the redirect this cycle
//   csr_wb_ex        one-cycle exception commit strobe (same cycle as WB)
//   csr_wb_ecode     ecode for the commit
//   csr_wb_esubcode  esubcode for the commit (always zero)
//   csr_wb_pc        value to write into ERA
//   csr_wb_vaddr     value to write into BADV
//   csr_ertn_flush   one-cycle ERTN commit strobe
//   flush_req        redirect request to fetch, held until fe_ready
//   flush_pc         redirect target, stable while flush_req is high
//   wb_block         WB must squash its instruction
//   exc_cnt          number of exceptions taken, saturating
//------------------------------------------------------------------------------
module exc_flush_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic [31:0]      wb_vaddr,
  input  logic [4:0]       wb_exc,
  input  logic             wb_ertn,
  input  logic             csr_crmd_ie,
  input  logic [12:0]      csr_estat_is,
  input  logic [12:0]      csr_ecfg_lie,
  input  logic [31:0]      csr_eentry,
  input  logic [31:0]      csr_era,
  input  logic             fe_ready,
  output logic             csr_wb_ex,
  output logic [5:0]       csr_wb_ecode,
  output logic [8:0]       csr_wb_esubcode,
  output logic [31:0]      csr_wb_pc,
  output logic [31:0]      csr_wb_vaddr,
  output logic             csr_ertn_flush,
  output logic             flush_req,
  output logic [31:0]      flush_pc,
  output logic             wb_block,
  output logic [CNT_W-1:0] exc_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Drain counter is loaded with DRAIN_CYCLES-1 so the DRAIN state lasts
  // exactly DRAIN_CYCLES cycles (the zero cycle included).
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_e           state_r;
  logic [3:0]       drain_cnt_r;
  logic             flush_req_r;
  logic [31:0]      flush_pc_r;
  logic [CNT_W-1:0] exc_cnt_r;

  logic             int_pend_s;
  logic             idle_s;
  logic             take_ex_s;
  logic             ertn_s;
  logic [5:0]       ecode_s;

  // Fixed-priority cause encoder: INT > ADEF > INE > SYS > BRK > ALE.
  // Flag order in exc is {ale,brk,sys,ine,adef}.
  function automatic logic [5:0] cause_ecode(input logic intp, input logic [4:0] exc);
    logic [5:0] code;
    if (intp) begin
      code = 6'h00;
    end else if (exc[0]) begin
      code = 6'h08;
    end else if (exc[1]) begin
      code = 6'h0D;
    end else if (exc[2]) begin
      code = 6'h0B;
    end else if (exc[3]) begin
      code = 6'h0C;
    end else if (exc[4]) begin
      code = 6'h09;
    end else begin
      code = 6'h00;
    end
    return code;
  endfunction

`ifdef CSR_EXC_INT_EN
  // Interrupt pending when globally enabled and any enabled line is asserted.
  assign int_pend_s = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
`else
  // Interrupts disabled in this build: the CSR interrupt inputs are only
  // folded into a sink so they are visibly intentionally unused.
  logic unused_int_s;
  assign unused_int_s = ^{csr_crmd_ie, csr_estat_is, csr_ecfg_lie};
  assign int_pend_s   = 1'b0;
`endif

  // Commit decision for the current WB instruction. Strobes are held low while
  // resetn is asserted so nothing commits during reset.
  always_comb begin
    idle_s    = (state_r == ST_IDLE);
    take_ex_s = resetn & idle_s & wb_valid & (int_pend_s | (|wb_exc));
    ertn_s    = resetn & idle_s & wb_valid & wb_ertn & ~take_ex_s;
    if (take_ex_s) begin
      ecode_s = cause_ecode(int_pend_s, wb_exc);
    end else begin
      ecode_s = 6'h00;
    end
  end

  // Redirect/drain sequencer with registered flush request, target and counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 4'd0;
      flush_req_r <= 1'b0;
      flush_pc_r  <= 32'h0000_0000;
      exc_cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_ex_s) begin
            state_r     <= ST_REDIR;
            flush_req_r <= 1'b1;
            flush_pc_r  <= csr_eentry;
          end else if (ertn_s) begin
            state_r     <= ST_REDIR;
            flush_req_r <= 1'b1;
            flush_pc_r  <= csr_era;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_REDIR: begin
          // flush_pc_r is untouched here so the target is stable while requested.
          if (fe_ready) begin
            state_r     <= ST_DRAIN;
            flush_req_r <= 1'b0;
            drain_cnt_r <= DRAIN_LOAD;
          end else begin
            state_r     <= ST_REDIR;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == 4'd0) begin
            state_r     <= ST_IDLE;
          end else begin
            drain_cnt_r <= drain_cnt_r - 4'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          drain_cnt_r <= 4'd0;
          flush_req_r <= 1'b0;
        end
      endcase

      // Saturating count of exceptions taken; ERTN is not an exception.
      if (take_ex_s && (exc_cnt_r != {CNT_W{1'b1}})) begin
        exc_cnt_r <= exc_cnt_r + CNT_W'(1);
      end
    end
  end

  assign csr_wb_ex       = take_ex_s;
  assign csr_wb_ecode    = ecode_s;
  assign csr_wb_esubcode = 9'd0;
  assign csr_wb_pc       = wb_pc;
  assign csr_wb_vaddr    = wb_vaddr;
  assign csr_ertn_flush  = ertn_s;
  assign wb_block        = ~idle_s | take_ex_s;
  assign flush_req       = flush_req_r;
  assign flush_pc        = flush_pc_r;
  assign exc_cnt         = exc_cnt_r;

endmodule

// File: tb/tb_exc_flush_ctrl.sv
module tb_exc_flush_ctrl;

  localparam int DRAIN = 2;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          resetn;
  logic          wb_valid;
  logic [31:0]   wb_pc;
  logic [31:0]   wb_vaddr;
  logic [4:0]    wb_exc;
  logic          wb_ertn;
  logic          csr_crmd_ie;
  logic [12:0]   csr_estat_is;
  logic [12:0]   csr_ecfg_lie;
  logic [31:0]   csr_eentry;
  logic [31:0]   csr_era;
  logic          fe_ready;
  logic          csr_wb_ex;
  logic [5:0]    csr_wb_ecode;
  logic [8:0]    csr_wb_esubcode;
  logic [31:0]   csr_wb_pc;
  logic [31:0]   csr_wb_vaddr;
  logic          csr_ertn_flush;
  logic          flush_req;
  logic [31:0]   flush_pc;
  logic          wb_block;
  logic [CW-1:0] exc_cnt;

  exc_flush_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .wb_exc(wb_exc), .wb_ertn(wb_ertn),
    .csr_crmd_ie(csr_crmd_ie), .csr_estat_is(csr_estat_is),
    .csr_ecfg_lie(csr_ecfg_lie), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .fe_ready(fe_ready), .csr_wb_ex(csr_wb_ex), .csr_wb_ecode(csr_wb_ecode),
    .csr_wb_esubcode(csr_wb_esubcode), .csr_wb_pc(csr_wb_pc),
    .csr_wb_vaddr(csr_wb_vaddr), .csr_ertn_flush(csr_ertn_flush),
    .flush_req(flush_req), .flush_pc(flush_pc), .wb_block(wb_block),
    .exc_cnt(exc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a redirect is either outstanding (waiting for fetch) or
  // the pipeline is still draining for some number of cycles; otherwise idle.
  bit          m_pend  = 1'b0;
  int          m_drain = 0;
  logic [31:0] m_pc    = 32'h0;
  int          m_cnt   = 0;

  // Samples from the last checked cycle, for directed follow-up checks.
  logic s_wb_ex, s_block, s_ertn;
  int   fr_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ref_ecode(input bit intp, input logic [4:0] e);
    // Walk causes from highest to lowest priority.
    int order[5]     = '{0, 1, 2, 3, 4};   // adef, ine, sys, brk, ale bit positions
    int code_of[5]   = '{8, 13, 11, 12, 9};
    if (intp) return 6'h00;
    order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 4;
    for (int k = 0; k < 5; k++) begin
      if (e[order[k]]) return 6'(code_of[k]);
    end
    return 6'h00;
  endfunction

  // One clock cycle: check all outputs at the negedge against the model,
  // then advance the model across the posedge.
  task automatic step();
    bit idle, intp, take, ertn;
    @(negedge clk);
    idle = !m_pend && (m_drain == 0);
`ifdef CSR_EXC_INT_EN
    intp = csr_crmd_ie && ((csr_estat_is & csr_ecfg_lie) != 13'd0);
`else
    intp = 1'b0;
`endif
    take = resetn && idle && wb_valid && (intp || wb_exc != 5'd0);
    ertn = resetn && idle && wb_valid && wb_ertn && !take;
    check("wb_ex",     {31'd0, csr_wb_ex},      {31'd0, take});
    check("ertn",      {31'd0, csr_ertn_flush}, {31'd0, ertn});
    check("block",     {31'd0, wb_block},       {31'd0, (!idle || take)});
    check("flush_req", {31'd0, flush_req},      {31'd0, m_pend});
    check("flush_pc",  flush_pc,                m_pc);
    check("exc_cnt",   32'(exc_cnt),            32'(m_cnt));
    check("esub",      32'(csr_wb_esubcode),    32'd0);
    if (take) begin
      check("ecode", 32'(csr_wb_ecode), 32'(ref_ecode(intp, wb_exc)));
      check("era_pc", csr_wb_pc, wb_pc);
      check("badv",   csr_wb_vaddr, wb_vaddr);
    end
    s_wb_ex = csr_wb_ex; s_block = wb_block; s_ertn = csr_ertn_flush;
    if (flush_req) fr_cycles++;
    @(posedge clk);
    if (!resetn) begin
      m_pend = 1'b0; m_drain = 0; m_pc = 32'h0; m_cnt = 0;
    end else if (idle) begin
      if (take) begin
        m_pend = 1'b1; m_pc = csr_eentry;
        if (m_cnt < CMAX) m_cnt++;
      end else if (ertn) begin
        m_pend = 1'b1; m_pc = csr_era;
      end
    end else if (m_pend) begin
      if (fe_ready) begin m_pend = 1'b0; m_drain = DRAIN; end
    end else begin
      m_drain--;
    end
    #1;
  endtask

  task automatic quiet(input int n);
    wb_valid = 1'b0; wb_exc = 5'd0; wb_ertn = 1'b0; fe_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    resetn = 1'b0; wb_valid = 1'b0; wb_pc = 32'h1c00_0040; wb_vaddr = 32'h0;
    wb_exc = 5'd0; wb_ertn = 1'b0; csr_crmd_ie = 1'b0; csr_estat_is = 13'd0;
    csr_ecfg_lie = 13'd0; csr_eentry = 32'h1c00_8000; csr_era = 32'h1c00_0100;
    fe_ready = 1'b1;
    @(posedge clk); #1;
    step();                                   // reset held: everything zero
    resetn = 1'b1;
    step();

    // SYS exception
    wb_valid = 1'b1; wb_exc = 5'b00100; csr_eentry = 32'h1c00_8000; fe_ready = 1'b1;
    step();
    check("sys_strobe", {31'd0, s_wb_ex}, 32'd1);
    check("sys_freq",   {31'd0, flush_req}, 32'd1);
    check("sys_fpc",    flush_pc, 32'h1c00_8000);
    check("sys_cnt",    32'(exc_cnt), 32'd1);
    quiet(4);

    // All flags: ADEF wins
    wb_valid = 1'b1; wb_exc = 5'b11111; wb_vaddr = 32'hdead_beef; wb_pc = 32'h1c00_0044;
    step();
    quiet(4);

    // Interrupt request (taken only when the interrupt build is enabled)
    wb_valid = 1'b1; csr_crmd_ie = 1'b1; csr_estat_is = 13'h0800; csr_ecfg_lie = 13'h0800;
    step();
    csr_crmd_ie = 1'b0;
    quiet(4);

    // ERTN
    wb_valid = 1'b1; wb_ertn = 1'b1; csr_era = 32'h1c00_0100;
    step();
    check("ertn_strobe", {31'd0, s_ertn}, 32'd1);
    check("ertn_fpc",    flush_pc, 32'h1c00_0100);
    quiet(4);

    // ERTN carrying INE: the exception wins
    wb_valid = 1'b1; wb_ertn = 1'b1; wb_exc = 5'b00010;
    step();
    check("ertn_ine_ex", {31'd0, s_wb_ex}, 32'd1);
    check("ertn_ine_er", {31'd0, s_ertn},  32'd0);
    quiet(4);

    // Fetch stalls 5 cycles; WB sys pulses during the window are blocked
    wb_valid = 1'b1; wb_exc = 5'b00100; fe_ready = 1'b0; csr_eentry = 32'h1c00_9000;
    step();
    fr_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      wb_valid = i[0]; fe_ready = 1'b0;
      step();
      check("stall_noex", {31'd0, s_wb_ex}, 32'd0);
    end
    fe_ready = 1'b1; wb_valid = 1'b1;
    step();                                   // accept cycle
    for (int i = 0; i < DRAIN; i++) begin
      step();
      check("drain_blk", {31'd0, s_block}, 32'd1);
    end
    check("stall_len", 32'(fr_cycles), 32'd6);
    step();                                   // back in IDLE: sys taken
    check("post_drain", {31'd0, s_wb_ex}, 32'd1);
    quiet(4);

    // Saturation: 5 more exceptions leave the 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1'b1; wb_exc = 5'b01000; fe_ready = 1'b1;
      step();
      quiet(3);
    end
    check("sat_cnt", 32'(exc_cnt), 32'd3);

    // Reset while a redirect is outstanding
    wb_valid = 1'b1; wb_exc = 5'b10000; fe_ready = 1'b0;
    step();
    wb_valid = 1'b0; wb_exc = 5'd0;
    step();
    resetn = 1'b0;
    step();
    check("rst_freq", {31'd0, flush_req}, 32'd0);
    check("rst_cnt",  32'(exc_cnt), 32'd0);
    resetn = 1'b1;
    quiet(2);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      wb_valid     = 1'($urandom_range(0, 1));
      wb_exc       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      wb_ertn      = ($urandom_range(0, 3) == 0);
      wb_pc        = $urandom;
      wb_vaddr     = $urandom;
      csr_crmd_ie  = 1'($urandom_range(0, 1));
      csr_estat_is = 13'($urandom) & 13'($urandom);
      csr_ecfg_lie = 13'($urandom);
      csr_eentry   = $urandom;
      csr_era      = $urandom;
      fe_ready     = ($urandom_range(0, 2) != 0);
      resetn       = ($urandom_range(0, 60) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
